fft_framer: RTL
===============

FFT_FRAMER -- requirements
Module: fft_framer

Interface
REQ-001 SHALL have parameter IN_W, default 8: signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 16: output word width; OUT_W >= IN_W.
REQ-003 SHALL have parameter FRAME_LEN, default 4096: samples per frame; power of two, >= 8.
REQ-004 SHALL have parameter HOP, default 2048: new samples between frame launches; power of two, 1 <= HOP <= FRAME_LEN.
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_sample  input  IN_W  signed audio sample.
REQ-008 SHALL have port in_valid  input  1  single-cycle qualifier for in_sample.
REQ-009 SHALL have port m_tdata  output  OUT_W  frame sample to FFT core.
REQ-010 SHALL have port m_tvalid  output  1  m_tdata valid.
REQ-011 SHALL have port m_tlast  output  1  last beat of frame.
REQ-012 SHALL have port m_tready  input  1  downstream accept.
REQ-013 SHALL have port overflow  output  1  sticky: at least one sample dropped.
REQ-014 SHALL have port busy  output  1  high while a frame is streaming or pending.

Function
REQ-015 SHALL store samples in a circular buffer of depth 2*FRAME_LEN with a write pointer that wraps modulo 2*FRAME_LEN.
REQ-016 SHALL use states FILL (after reset, until FRAME_LEN samples written), IDLE (counting HOP new samples), STREAM (emitting a frame).
REQ-017 SHALL launch the first frame when the FRAME_LEN-th sample is written, and each later frame when HOP further samples have been written since the previous launch.
REQ-018 SHALL make each frame the FRAME_LEN most recent samples at launch, oldest first; frames overlap by FRAME_LEN-HOP samples.
REQ-019 SHALL latch the frame's end pointer at launch; writes during STREAM do not alter the frame contents.
REQ-020 SHALL, if a launch point occurs during STREAM, hold one pending launch and enter STREAM again on the cycle after the current m_tlast handshake, with no gap beat.
REQ-021 SHALL drive m_tdata as in_sample sign-extended to OUT_W.
REQ-022 SHALL assert m_tlast only on beat FRAME_LEN-1 of each frame.
REQ-023 SHALL follow AXI-stream rules: beat transfers on m_tvalid && m_tready; m_tdata/m_tlast held stable while m_tvalid && !m_tready; m_tvalid never deasserted before transfer.
REQ-024 SHALL sustain one beat per cycle with m_tready high; first beat m_tvalid within 2 cycles of the launching sample's write.
REQ-025 SHALL drop an incoming sample (no write, no pointer advance) when writing it would overwrite an unread sample of the streaming or pending frame, and set overflow.
REQ-026 SHALL accept a write and a read in the same cycle, including to adjacent addresses.
REQ-027 SHALL count a dropped sample toward neither the FRAME_LEN fill nor the HOP count.

Reset
REQ-028 SHALL, while rst_in is high, asynchronously force m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, busy=0, pointers and counters 0, state FILL, pending cleared.
REQ-029 SHALL discard any partial or pending frame on reset; buffer RAM contents need not be cleared.

Configuration
REQ-030 SHALL, with macro FFT_FRAMER_OVF_CNT_EN defined, add output port ovf_count  output  16  count of dropped samples, saturating at 16'hFFFF, reset to 0.
REQ-031 SHALL, without FFT_FRAMER_OVF_CNT_EN, omit ovf_count and its counter; all other behaviour identical.

Verification (FRAME_LEN=16, HOP=8, IN_W=8, OUT_W=16)
REQ-032 SHALL check: samples 0..15, m_tready=1 -> no m_tvalid before sample 15; then 16 beats 0..15, m_tlast on value 15.
REQ-033 SHALL check: continue samples 16..23 -> second frame 8..23; no further frame until sample 31.
REQ-034 SHALL check: in_sample=8'h80 within a frame -> corresponding beat m_tdata=16'hFF80; 8'h7F -> 16'h007F.
REQ-035 SHALL check: m_tready low 5 cycles mid-frame -> m_tdata/m_tlast frozen, no beat lost or duplicated.
REQ-036 SHALL check: m_tready=0 always, feed 40 samples -> samples 16..31 stored, 32..39 dropped, overflow=1, ovf_count=8 when enabled.
REQ-037 SHALL check: rst_in pulsed at beat 5 -> m_tvalid=0 immediately, overflow=0; next frame only after 16 fresh samples.

Source files
------------

// File: rtl/fft_framer.sv
// Overlapping-frame buffer feeding an AXI-stream FFT core from a sample stream.
// Define FFT_FRAMER_OVF_CNT_EN to add the ovf_count dropped-sample counter port.
module fft_framer #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int FRAME_LEN = 4096,
  parameter int HOP       = 2048
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [IN_W-1:0]  in_sample,
  input  logic                    in_valid,
  output logic [OUT_W-1:0]        m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    overflow,
  output logic                    busy
`ifdef FFT_FRAMER_OVF_CNT_EN
  ,
  output logic [15:0]             ovf_count
`endif
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] FL   = AW'(FRAME_LEN);
  localparam logic [AW-1:0] FL1  = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] HOP1 = AW'(HOP - 1);

  typedef enum logic [1:0] {FILL, IDLE, STREAM} state_t;

  logic signed [IN_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     left_q, left_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     pend_end_q, pend_end_d;
  logic              pend_q, pend_d;
  logic [OUT_W-1:0]  tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic [AW-1:0]     u_start, u_len, p_start, src;
  logic signed [IN_W-1:0] rd_word;
  logic              full, wr_en, drop, launch;
  logic              from_pend, load;

  always_comb begin
    // protected region: held beat + unissued beats, plus pending frame
    u_start = rd_q - AW'(tvalid_q);
    u_len   = left_q + AW'(tvalid_q);
    p_start = pend_end_q - FL1;
    full    = ((wp_q - u_start) < u_len) ||
              (pend_q && ((wp_q - p_start) < FL));
    wr_en   = in_valid && !full;
    drop    = in_valid && full;
    launch  = wr_en &&
              (cnt_q == ((state_q == FILL) ? FL1 : HOP1));
    cnt_d   = launch ? '0 : cnt_q + (wr_en ? ONE : '0);
    wp_d    = wp_q + (wr_en ? ONE : '0);

    from_pend = (left_q == '0);
    load      = (!tvalid_q || m_tready) && (!from_pend || pend_q);
    src       = from_pend ? p_start : rd_q;
    rd_word   = mem[src];

    rd_d       = rd_q;
    left_d     = left_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pend_d     = pend_q;
    pend_end_d = pend_end_q;

    if (load) begin
      tdata_d  = OUT_W'(rd_word);
      tvalid_d = 1'b1;
      rd_d     = src + ONE;
      left_d   = from_pend ? FL1 : left_q - ONE;
      tlast_d  = (left_d == '0);
      if (from_pend) pend_d = 1'b0;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    // a newer launch replaces an older one still waiting
    if (launch) begin
      pend_d     = 1'b1;
      pend_end_d = wp_q;
    end

    ovf_d = ovf_q | drop;

    if (state_q == FILL && !launch)
      state_d = FILL;
    else if (pend_d || tvalid_d || left_d != '0)
      state_d = STREAM;
    else
      state_d = IDLE;
    busy_d = (state_d == STREAM);
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wp_q] <= in_sample;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= FILL;
      wp_q       <= '0;
      rd_q       <= '0;
      left_q     <= '0;
      cnt_q      <= '0;
      pend_end_q <= '0;
      pend_q     <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rd_q       <= rd_d;
      left_q     <= left_d;
      cnt_q      <= cnt_d;
      pend_end_q <= pend_end_d;
      pend_q     <= pend_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

`ifdef FFT_FRAMER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != 16'hFFFF)
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule
